// File: rtl/tmr_pkg.sv
// Shared types and default sizing for the timeout arbiter.
package tmr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam int DEF_PRESCALE = 100_000;
  localparam int DEF_DUR_W    = 8;

endpackage

// File: rtl/tmr_arb_if.sv
// Request/grant bundle between the requesters (master) and the shared timer arbiter (slave).
interface tmr_arb_if #(
  parameter int N_REQ = 4,
  parameter int DUR_W = tmr_pkg::DEF_DUR_W
);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*DUR_W-1:0] dur;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;

  modport master (output req, dur, input grant, done, busy);
  modport slave  (input req, dur, output grant, done, busy);

endinterface

// File: rtl/presc_cnt.sv
// Time-unit prescaler: counts 0..PRESCALE-1 while enabled and pulses wrap on the last count.
module presc_cnt #(
  parameter int PRESCALE = tmr_pkg::DEF_PRESCALE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap
);

  localparam int CW = $clog2(PRESCALE);

  logic [CW-1:0] cnt;

  assign wrap = en && (cnt == CW'(PRESCALE - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/tmr_arb.sv
// Round-robin arbiter that lends one shared prescaled timer to N_REQ requesters in turn.
module tmr_arb
  import tmr_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int PRESCALE = DEF_PRESCALE,
  parameter int DUR_W    = DEF_DUR_W
) (
  input  logic      clk,
  input  logic      rst_n,
  tmr_arb_if.slave  bus
);

  localparam int IW = $clog2(N_REQ);
  typedef logic [IW-1:0] id_t;

  state_t           state, state_nxt;
  id_t              own_id, own_id_nxt;
  id_t              last_id, last_id_nxt;
  id_t              win_id, cand;
  logic             win_vld;
  logic [DUR_W-1:0] win_dur;
  logic [N_REQ-1:0] grant_q, grant_nxt;
  logic [DUR_W-1:0] remain, remain_nxt;
  logic             wrap;
  int               idx;

  presc_cnt #(.PRESCALE(PRESCALE)) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_RUN),
    .en    (state == ST_RUN),
    .wrap  (wrap)
  );

  // Scan offsets from farthest to nearest so the nearest requester after last_id wins.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = 0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last_id) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = id_t'(idx);
      if (bus.req[cand]) begin
        win_vld = 1'b1;
        win_id  = cand;
      end
    end
  end

  assign win_dur = bus.dur[int'(win_id)*DUR_W +: DUR_W];

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    own_id_nxt  = own_id;
    last_id_nxt = last_id;
    grant_nxt   = grant_q;
    remain_nxt  = remain;
    unique case (state)
      ST_IDLE: begin
        if (win_vld) begin
          own_id_nxt = win_id;
          grant_nxt  = N_REQ'(1) << win_id;
          remain_nxt = win_dur;
          state_nxt  = (win_dur == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!bus.req[own_id]) begin
          // Abort wins over a coinciding final wrap.
          state_nxt   = ST_IDLE;
          grant_nxt   = '0;
          remain_nxt  = '0;
          last_id_nxt = own_id;
        end else if (wrap) begin
          if (remain <= DUR_W'(1)) begin
            state_nxt  = ST_DONE;
            remain_nxt = '0;
          end else begin
            remain_nxt = remain - DUR_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_nxt   = ST_IDLE;
        grant_nxt   = '0;
        last_id_nxt = own_id;
      end
      default: begin
        state_nxt = ST_IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  // NOTE: only control/status flops exist here, so all of them take the async reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      own_id  <= '0;
      last_id <= id_t'(N_REQ - 1);
      grant_q <= '0;
      remain  <= '0;
    end else begin
      state   <= state_nxt;
      own_id  <= own_id_nxt;
      last_id <= last_id_nxt;
      grant_q <= grant_nxt;
      remain  <= remain_nxt;
    end
  end

  assign bus.grant = grant_q;
  assign bus.done  = (state == ST_DONE) ? grant_q : '0;
  assign bus.busy  = |grant_q;

endmodule

// File: tb/tb_tmr_arb.sv
// Directed bench for tmr_arb with PRESCALE=4, DUR_W=8, N_REQ=4.
module tb_tmr_arb;

  logic clk;
  logic rst_n;
  int   vectors = 0;
  int   fails   = 0;
  logic [3:0] seen;
  logic [3:0] exp_g;

  tmr_arb_if #(.N_REQ(4), .DUR_W(8)) bus ();

  tmr_arb #(.N_REQ(4), .PRESCALE(4), .DUR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    bus.req = '0;
    bus.dur = '0;
    #2;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_done",  32'(bus.done),  32'h0);
    check("rst_busy",  32'(bus.busy),  32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single requester, dur=3: done 12 cycles after grant.
    bus.req = 4'b0001;
    bus.dur[7:0] = 8'd3;
    tick();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_busy",  32'(bus.busy),  32'h1);
    seen = '0;
    repeat (11) begin tick(); seen |= bus.done; end
    check("t1_early_done", 32'(seen), 32'h0);
    tick();
    check("t1_done",       32'(bus.done),  32'h1);
    check("t1_done_grant", 32'(bus.grant), 32'h1);
    bus.req = '0;
    tick();
    check("t1_idle_busy",  32'(bus.busy),  32'h0);
    check("t1_idle_grant", 32'(bus.grant), 32'h0);

    // All four requesting with dur=1: round-robin from requester 0.
    do_reset();
    bus.req = 4'b1111;
    bus.dur = {4{8'd1}};
    tick();
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      check("t2_grant", 32'(bus.grant), 32'(exp_g));
      repeat (3) tick();
      check("t2_no_done", 32'(bus.done), 32'h0);
      tick();
      check("t2_done", 32'(bus.done), 32'(exp_g));
      if (k == 4) bus.req = '0;
      tick();
      check("t2_idle_gap", 32'(bus.grant), 32'h0);
      if (k < 4) tick();
    end

    // Zero duration: grant and done together one cycle after req.
    bus.req = 4'b0010;
    bus.dur = '0;
    tick();
    check("t3_grant", 32'(bus.grant), 32'h2);
    check("t3_done",  32'(bus.done),  32'h2);
    bus.req = '0;
    tick();
    check("t3_idle_grant", 32'(bus.grant), 32'h0);
    check("t3_idle_busy",  32'(bus.busy),  32'h0);

    // Owner drops mid-RUN: abort, then the pending requester 3 is served.
    bus.req = 4'b1100;
    bus.dur[23:16] = 8'd5;
    bus.dur[31:24] = 8'd1;
    tick();
    check("t4_grant", 32'(bus.grant), 32'h4);
    seen = '0;
    repeat (6) begin tick(); seen |= bus.done; end
    bus.req[2] = 1'b0;
    tick();
    seen |= bus.done;
    check("t4_abort_grant", 32'(bus.grant), 32'h0);
    check("t4_abort_nodone", 32'(seen), 32'h0);
    tick();
    check("t4_next_grant", 32'(bus.grant), 32'h8);
    repeat (3) tick();
    check("t4_next_no_done", 32'(bus.done), 32'h0);
    tick();
    check("t4_next_done", 32'(bus.done), 32'h8);
    bus.req = '0;
    tick();
    check("t4_idle_grant", 32'(bus.grant), 32'h0);

    // Asynchronous reset mid-RUN.
    bus.req = 4'b0011;
    bus.dur = '0;
    bus.dur[7:0]  = 8'd3;
    bus.dur[15:8] = 8'd3;
    tick();
    check("t5_grant", 32'(bus.grant), 32'h1);
    repeat (2) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_grant", 32'(bus.grant), 32'h0);
    check("t5_rst_busy",  32'(bus.busy),  32'h0);
    check("t5_rst_done",  32'(bus.done),  32'h0);
    tick();
    check("t5_held_grant", 32'(bus.grant), 32'h0);
    rst_n = 1'b1;
    tick();
    check("t5_regrant", 32'(bus.grant), 32'h1);

    // Owner drops on the final-wrap cycle: abort takes precedence.
    seen = '0;
    repeat (11) begin tick(); seen |= bus.done; end
    bus.req[0] = 1'b0;
    tick();
    seen |= bus.done;
    check("t6_nodone",      32'(seen),      32'h0);
    check("t6_abort_grant", 32'(bus.grant), 32'h0);
    tick();
    check("t6_next_grant", 32'(bus.grant), 32'h2);
    bus.req = '0;
    tick();
    check("t6_idle_grant", 32'(bus.grant), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/tmr_arb.md
TMR_ARB -- requirements
Module: tmr_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 SHALL have parameter PRESCALE, default 100_000: clk cycles per time unit (1 ms @100 MHz), minimum 2.
REQ-003 SHALL have parameter DUR_W, default 8: width of each duration field, in time units.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port req  input  N_REQ: per-requester timeout request, level, held until done.
REQ-007 SHALL have port dur  input  N_REQ*DUR_W: duration of requester i in bits [i*DUR_W +: DUR_W], sampled at grant.
REQ-008 SHALL have port grant  output  N_REQ: one-hot owner of the shared timer; all-zero when idle.
REQ-009 SHALL have port done  output  N_REQ: one-hot, 1-cycle expiry pulse to the owner.
REQ-010 SHALL have port busy  output  1: high while any grant bit is high.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-012 In IDLE with any req high, SHALL select the winner by round-robin, searching from (last_id+1) mod N_REQ upward; last_id resets to N_REQ-1, so requester 0 has first priority after reset.
REQ-013 On selection, SHALL latch the winner's dur into the remaining-unit counter, clear the prescaler, and register grant one-hot on the next edge.
REQ-014 If the latched dur is 0, SHALL go IDLE->DONE directly, with grant and done both high one cycle after req is sampled.
REQ-015 Otherwise SHALL go IDLE->RUN; in RUN the prescaler SHALL count 0..PRESCALE-1 and wrap, decrementing remaining on each wrap.
REQ-016 On the wrap at which remaining equals 1, SHALL go RUN->DONE; done[id] SHALL go high exactly dur*PRESCALE cycles after grant first goes high.
REQ-017 In DONE, SHALL hold grant[id] and done[id] high for exactly one cycle, update last_id to id, and return to IDLE.
REQ-018 grant SHALL be all-zero in IDLE; IDLE SHALL last at least one cycle between two grants.
REQ-019 If req[id] is low during any RUN cycle, SHALL abort: next state IDLE, no done pulse, last_id updated to id.
REQ-020 If the abort condition and the final wrap occur in the same cycle, abort SHALL take precedence.
REQ-021 Changes to req or dur of non-owners during RUN SHALL have no effect; changes to the owner's dur after grant SHALL be ignored.
REQ-022 Prescaler width SHALL be $clog2(PRESCALE) and the remaining counter SHALL be DUR_W bits; neither SHALL ever wrap below zero.
REQ-023 If req[id] is still high in the IDLE cycle after DONE, SHALL treat it as a new request at lowest round-robin priority.

Reset
REQ-024 On rst_n low, SHALL immediately force state IDLE, grant=0, done=0, busy=0, prescaler=0, remaining=0, last_id=N_REQ-1, regardless of clk.
REQ-025 Reset asserted mid-RUN SHALL discard the pending timeout with no done pulse; release SHALL be synchronous to the clk edge.

Structure
REQ-026 A shared package tmr_pkg SHALL hold the state enum type and the default values of PRESCALE and DUR_W.
REQ-027 The prescaler SHALL be a sub-module presc_cnt with ports clk, rst_n, clr, en, and wrap (1-cycle pulse at count PRESCALE-1).
REQ-028 The round-robin winner search SHALL be purely combinational inside tmr_arb, with no additional latency.

Verification (bench: PRESCALE=4, DUR_W=8, N_REQ=4)
REQ-029 req=0001, dur0=3 -> grant=0001 next cycle, done[0] exactly 12 cycles after grant rises, then busy=0.
REQ-030 req=1111 held, all dur=1 -> grants in order 0001, 0010, 0100, 1000, 0001, each done 4 cycles after its grant.
REQ-031 req=0010, dur1=0 -> grant=0010 and done=0010 in the same cycle, one cycle after req; IDLE follows.
REQ-032 req=0100, dur2=5, req[2] dropped after 7 cycles of RUN -> no done, IDLE next cycle; a pending req[3] is then granted.
REQ-033 rst_n pulsed low mid-RUN, asynchronous to clk -> grant=0 and busy=0 immediately, no done; the next grant goes to the lowest pending index.
REQ-034 req[0] drops on the final-wrap cycle -> no done pulse (abort precedence).
